// File: rtl/decode_sequencer.sv
// Top-level decode controller: sequences UART load, M3, M2, M1 and arbitrates the single SRAM port.
// Each wait state has a watchdog, and a cycle counter measures the length of a full decode.
module decode_sequencer #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd4194304,
   parameter bit          SKIP_UART      = 1'b0
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        start,
   input  logic        uart_done,
   input  logic [17:0] uart_address,
   input  logic [15:0] uart_write_data,
   input  logic        uart_we_n,
   input  logic [17:0] m3_address,
   input  logic [15:0] m3_write_data,
   input  logic        m3_we_n,
   input  logic [17:0] m2_address,
   input  logic [15:0] m2_write_data,
   input  logic        m2_we_n,
   input  logic [17:0] m1_address,
   input  logic [15:0] m1_write_data,
   input  logic        m1_we_n,
   output logic        m3_start,
   output logic        m2_start,
   output logic        m1_start,
   input  logic        m3_done,
   input  logic        m2_done,
   input  logic        m1_done,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic [2:0]  stage,
   output logic        busy,
   output logic        done,
   output logic        timeout_err,
   output logic [31:0] cycle_count
);

   typedef enum logic [3:0] {
      S_IDLE, S_UART_WAIT, S_M3_START, S_M3_WAIT, S_M2_START, S_M2_WAIT,
      S_M1_START, S_M1_WAIT, S_FINISH, S_ERROR
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] watchdog;
   logic        wd_hit;
   logic        accept;

   function automatic logic [2:0] stage_of(input state_t s);
      unique case (s)
         S_UART_WAIT:            stage_of = 3'd1;
         S_M3_START, S_M3_WAIT:  stage_of = 3'd2;
         S_M2_START, S_M2_WAIT:  stage_of = 3'd3;
         S_M1_START, S_M1_WAIT:  stage_of = 3'd4;
         S_FINISH:               stage_of = 3'd5;
         S_ERROR:                stage_of = 3'd7;
         default:                stage_of = 3'd0;
      endcase
   endfunction

   function automatic logic busy_of(input state_t s);
      busy_of = !(s == S_IDLE || s == S_FINISH || s == S_ERROR);
   endfunction

   assign wd_hit = (watchdog == TIMEOUT_CYCLES - 32'd1);
   assign accept = (state == S_IDLE || state == S_ERROR) && start;

   // Only the current owner's done pulse advances; done beats a coincident timeout.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE, S_ERROR: if (start) state_nxt = SKIP_UART ? S_M3_START : S_UART_WAIT;
         S_UART_WAIT:     if (uart_done) state_nxt = S_M3_START; else if (wd_hit) state_nxt = S_ERROR;
         S_M3_START:      state_nxt = S_M3_WAIT;
         S_M3_WAIT:       if (m3_done) state_nxt = S_M2_START; else if (wd_hit) state_nxt = S_ERROR;
         S_M2_START:      state_nxt = S_M2_WAIT;
         S_M2_WAIT:       if (m2_done) state_nxt = S_M1_START; else if (wd_hit) state_nxt = S_ERROR;
         S_M1_START:      state_nxt = S_M1_WAIT;
         S_M1_WAIT:       if (m1_done) state_nxt = S_FINISH; else if (wd_hit) state_nxt = S_ERROR;
         S_FINISH:        state_nxt = S_IDLE;
         default:         state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state       <= S_IDLE;
         watchdog    <= '0;
         m3_start    <= 1'b0;
         m2_start    <= 1'b0;
         m1_start    <= 1'b0;
         stage       <= 3'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         cycle_count <= '0;
      end else begin
         state    <= state_nxt;
         m3_start <= (state_nxt == S_M3_START);
         m2_start <= (state_nxt == S_M2_START);
         m1_start <= (state_nxt == S_M1_START);
         stage    <= stage_of(state_nxt);
         busy     <= busy_of(state_nxt);
         done     <= (state_nxt == S_FINISH);

         // A WAIT state that persists keeps counting; any change of state restarts the watchdog.
         if (busy_of(state) && state_nxt == state) watchdog <= watchdog + 32'd1;
         else                                       watchdog <= '0;

         if (accept)                     timeout_err <= 1'b0;
         else if (state_nxt == S_ERROR)  timeout_err <= 1'b1;

         if (accept)                                        cycle_count <= '0;
         else if (busy_of(state) && cycle_count != '1)      cycle_count <= cycle_count + 32'd1;
      end
   end

   // SRAM port follows the registered owner; START/IDLE/FINISH/ERROR park it with writes disabled.
   always_comb begin
      SRAM_address    = '0;
      SRAM_write_data = '0;
      SRAM_we_n       = 1'b1;
      unique case (state)
         S_UART_WAIT: begin
            SRAM_address = uart_address; SRAM_write_data = uart_write_data; SRAM_we_n = uart_we_n;
         end
         S_M3_WAIT: begin
            SRAM_address = m3_address; SRAM_write_data = m3_write_data; SRAM_we_n = m3_we_n;
         end
         S_M2_WAIT: begin
            SRAM_address = m2_address; SRAM_write_data = m2_write_data; SRAM_we_n = m2_we_n;
         end
         S_M1_WAIT: begin
            SRAM_address = m1_address; SRAM_write_data = m1_write_data; SRAM_we_n = m1_we_n;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: instance a uses the default watchdog, instance b a
// 16-cycle watchdog for the timeout cases. Both share every input.
module tb_decode_sequencer;

   logic        Clock, Resetn, start, uart_done, m3_done, m2_done, m1_done;
   logic [3:0]  we_bus;   // bit0 uart, bit1 m3, bit2 m2, bit3 m1 (active low)
   logic [17:0] u_addr, m3_addr, m2_addr, m1_addr;
   logic [15:0] u_data, m3_data, m2_data, m1_data;

   logic        a_m3_start, a_m2_start, a_m1_start, a_we_n, a_busy, a_done, a_terr;
   logic [17:0] a_addr;
   logic [15:0] a_wdata;
   logic [2:0]  a_stage;
   logic [31:0] a_cc;
   logic        b_m3_start, b_m2_start, b_m1_start, b_we_n, b_busy, b_done, b_terr;
   logic [17:0] b_addr;
   logic [15:0] b_wdata;
   logic [2:0]  b_stage;
   logic [31:0] b_cc;

   decode_sequencer dut_a (
      .Clock(Clock), .Resetn(Resetn), .start(start), .uart_done(uart_done),
      .uart_address(u_addr), .uart_write_data(u_data), .uart_we_n(we_bus[0]),
      .m3_address(m3_addr), .m3_write_data(m3_data), .m3_we_n(we_bus[1]),
      .m2_address(m2_addr), .m2_write_data(m2_data), .m2_we_n(we_bus[2]),
      .m1_address(m1_addr), .m1_write_data(m1_data), .m1_we_n(we_bus[3]),
      .m3_start(a_m3_start), .m2_start(a_m2_start), .m1_start(a_m1_start),
      .m3_done(m3_done), .m2_done(m2_done), .m1_done(m1_done),
      .SRAM_address(a_addr), .SRAM_write_data(a_wdata), .SRAM_we_n(a_we_n),
      .stage(a_stage), .busy(a_busy), .done(a_done), .timeout_err(a_terr), .cycle_count(a_cc));

   decode_sequencer #(.TIMEOUT_CYCLES(32'd16), .SKIP_UART(1'b0)) dut_b (
      .Clock(Clock), .Resetn(Resetn), .start(start), .uart_done(uart_done),
      .uart_address(u_addr), .uart_write_data(u_data), .uart_we_n(we_bus[0]),
      .m3_address(m3_addr), .m3_write_data(m3_data), .m3_we_n(we_bus[1]),
      .m2_address(m2_addr), .m2_write_data(m2_data), .m2_we_n(we_bus[2]),
      .m1_address(m1_addr), .m1_write_data(m1_data), .m1_we_n(we_bus[3]),
      .m3_start(b_m3_start), .m2_start(b_m2_start), .m1_start(b_m1_start),
      .m3_done(m3_done), .m2_done(m2_done), .m1_done(m1_done),
      .SRAM_address(b_addr), .SRAM_write_data(b_wdata), .SRAM_we_n(b_we_n),
      .stage(b_stage), .busy(b_busy), .done(b_done), .timeout_err(b_terr), .cycle_count(b_cc));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int total = 0;
   int bad   = 0;
   int a_pulses = 0;
   int a_dones  = 0;

   always @(negedge Clock) begin
      if (a_m3_start || a_m2_start || a_m1_start) a_pulses++;
      if (a_done) a_dones++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Tags: 0 UART_WAIT, 1 M3_START, 2 M3_WAIT, 3 M2_START, 4 M2_WAIT, 5 M1_START, 6 M1_WAIT, 7 FINISH
   typedef struct {
      int          tag;
      logic [3:0]  we;
      logic [17:0] addr;
      logic [15:0] data;
      logic        wen;
   } vec_t;

   vec_t vecs[10];

   task automatic apply_vecs(input int tag);
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].tag == tag) begin
            we_bus = vecs[i].we;
            #1;
            chk($sformatf("sram_addr_v%0d", i), 32'(a_addr),  32'(vecs[i].addr));
            chk($sformatf("sram_data_v%0d", i), 32'(a_wdata), 32'(vecs[i].data));
            chk($sformatf("sram_wen_v%0d", i),  32'(a_we_n),  32'(vecs[i].wen));
         end
      end
      we_bus = 4'hF;
   endtask

   int p0, d0;

   initial begin
      u_addr  = 18'h01234; u_data  = 16'h1111;
      m3_addr = 18'h02345; m3_data = 16'h3333;
      m2_addr = 18'h03456; m2_data = 16'h2222;
      m1_addr = 18'd146944; m1_data = 16'hABCD;

      vecs[0] = '{0, 4'b1110, 18'h01234, 16'h1111, 1'b0};
      vecs[1] = '{0, 4'b0001, 18'h01234, 16'h1111, 1'b1};
      vecs[2] = '{1, 4'b0000, 18'h0,     16'h0,    1'b1};
      vecs[3] = '{2, 4'b1101, 18'h02345, 16'h3333, 1'b0};
      vecs[4] = '{3, 4'b0000, 18'h0,     16'h0,    1'b1};
      vecs[5] = '{4, 4'b1011, 18'h03456, 16'h2222, 1'b0};
      vecs[6] = '{5, 4'b0000, 18'h0,     16'h0,    1'b1};
      vecs[7] = '{6, 4'b0111, 18'd146944, 16'hABCD, 1'b0};
      vecs[8] = '{6, 4'b1011, 18'd146944, 16'hABCD, 1'b1};
      vecs[9] = '{7, 4'b0000, 18'h0,     16'h0,    1'b1};

      Resetn = 1'b0; start = 1'b0; uart_done = 1'b0;
      m3_done = 1'b0; m2_done = 1'b0; m1_done = 1'b0; we_bus = 4'h0;

      // Reset values, with every requester trying to write
      #12;
      chk("rst_stage", 32'(a_stage), 32'd0);
      chk("rst_busy",  32'(a_busy),  32'd0);
      chk("rst_done",  32'(a_done),  32'd0);
      chk("rst_terr",  32'(a_terr),  32'd0);
      chk("rst_cc",    a_cc,         32'd0);
      chk("rst_starts", 32'({a_m3_start, a_m2_start, a_m1_start}), 32'd0);
      chk("rst_wen",   32'(a_we_n),  32'd1);
      chk("rst_addr",  32'(a_addr),  32'd0);
      chk("rst_data",  32'(a_wdata), 32'd0);
      we_bus = 4'hF;
      @(negedge Clock); Resetn = 1'b1;
      @(negedge Clock);

      // Full decode; uart_done lands 10 cycles after start is released, each milestone
      // done 20/30/40 cycles after its launch pulse: 11+1+20+1+30+1+40 = 104 busy cycles.
      p0 = a_pulses; d0 = a_dones;
      start = 1'b1; @(negedge Clock); start = 1'b0;
      chk("t1_uart_stage", 32'(a_stage), 32'd1);
      chk("t1_uart_busy",  32'(a_busy),  32'd1);
      apply_vecs(0);
      repeat (10) @(negedge Clock);
      uart_done = 1'b1; @(negedge Clock); uart_done = 1'b0;
      chk("t1_m3_start", 32'({a_m3_start, a_m2_start, a_m1_start}), 32'b100);
      apply_vecs(1);
      @(negedge Clock);
      chk("t1_m3_start_low", 32'(a_m3_start), 32'd0);
      apply_vecs(2);
      repeat (19) @(negedge Clock);
      m3_done = 1'b1; @(negedge Clock); m3_done = 1'b0;
      chk("t1_m2_start", 32'({a_m3_start, a_m2_start, a_m1_start}), 32'b010);
      chk("t1_m2_stage", 32'(a_stage), 32'd3);
      apply_vecs(3);
      @(negedge Clock);
      apply_vecs(4);
      repeat (29) @(negedge Clock);
      m2_done = 1'b1; @(negedge Clock); m2_done = 1'b0;
      chk("t1_m1_start", 32'({a_m3_start, a_m2_start, a_m1_start}), 32'b001);
      apply_vecs(5);
      @(negedge Clock);
      chk("t1_m1_stage", 32'(a_stage), 32'd4);
      apply_vecs(6);
      repeat (39) @(negedge Clock);
      m1_done = 1'b1; @(negedge Clock); m1_done = 1'b0;
      chk("t1_fin_done",  32'(a_done),  32'd1);
      chk("t1_fin_stage", 32'(a_stage), 32'd5);
      chk("t1_fin_busy",  32'(a_busy),  32'd0);
      chk("t1_fin_cc",    a_cc,         32'd104);
      apply_vecs(7);
      @(negedge Clock);
      chk("t1_idle_stage", 32'(a_stage), 32'd0);
      chk("t1_idle_done",  32'(a_done),  32'd0);
      chk("t1_idle_cc",    a_cc,         32'd104);
      chk("t1_pulse_cnt",  32'(a_pulses - p0), 32'd3);
      chk("t1_done_cnt",   32'(a_dones - d0),  32'd1);

      // Stray done pulses and start while busy are ignored
      start = 1'b1; @(negedge Clock); start = 1'b0;
      uart_done = 1'b1; @(negedge Clock); uart_done = 1'b0;
      chk("t5_m3_start", 32'(a_m3_start), 32'd1);
      m3_done = 1'b1; @(negedge Clock); m3_done = 1'b0;
      chk("t5_done_in_start", 32'(a_m2_start), 32'd0);
      chk("t5_m3wait_stage",  32'(a_stage), 32'd2);
      m1_done = 1'b1; m2_done = 1'b1; start = 1'b1;
      @(negedge Clock);
      m1_done = 1'b0; m2_done = 1'b0; start = 1'b0;
      chk("t5_stray_stage",  32'(a_stage), 32'd2);
      chk("t5_stray_starts", 32'({a_m3_start, a_m2_start, a_m1_start}), 32'd0);
      chk("t5_stray_cc",     a_cc, 32'd3);
      m3_done = 1'b1; @(negedge Clock); m3_done = 1'b0;
      chk("t5_m2_start", 32'(a_m2_start), 32'd1);
      @(negedge Clock);

      // Asynchronous reset in M2_WAIT while M2 is writing
      we_bus = 4'b1011; #1;
      chk("t6_pre_wen", 32'(a_we_n), 32'd0);
      Resetn = 1'b0; #1;
      chk("t6_stage", 32'(a_stage), 32'd0);
      chk("t6_busy",  32'(a_busy),  32'd0);
      chk("t6_cc",    a_cc,         32'd0);
      chk("t6_wen",   32'(a_we_n),  32'd1);
      chk("t6_addr",  32'(a_addr),  32'd0);
      we_bus = 4'hF;
      @(negedge Clock); Resetn = 1'b1;
      p0 = a_pulses;
      repeat (5) @(negedge Clock);
      chk("t6_no_pulses", 32'(a_pulses - p0), 32'd0);
      chk("t6_idle_stage", 32'(a_stage), 32'd0);

      // Watchdog (16 cycles) on instance b in M2_WAIT
      start = 1'b1; @(negedge Clock); start = 1'b0;
      uart_done = 1'b1; @(negedge Clock); uart_done = 1'b0;
      @(negedge Clock);
      m3_done = 1'b1; @(negedge Clock); m3_done = 1'b0;
      chk("t4_b_m2_start", 32'(b_m2_start), 32'd1);
      @(negedge Clock);
      repeat (15) @(negedge Clock);
      chk("t4_b_wait16_stage", 32'(b_stage), 32'd3);
      chk("t4_b_wait16_terr",  32'(b_terr),  32'd0);
      @(negedge Clock);
      chk("t4_b_err_stage", 32'(b_stage), 32'd7);
      chk("t4_b_err_terr",  32'(b_terr),  32'd1);
      chk("t4_b_err_busy",  32'(b_busy),  32'd0);
      chk("t4_a_still_m2",  32'(a_stage), 32'd3);
      we_bus = 4'h0; #1;
      chk("t4_b_err_wen",  32'(b_we_n), 32'd1);
      chk("t4_b_err_addr", 32'(b_addr), 32'd0);
      we_bus = 4'hF;
      @(negedge Clock);
      chk("t4_b_err_hold", 32'(b_terr), 32'd1);
      start = 1'b1; @(negedge Clock); start = 1'b0;
      chk("t4_b_restart_stage", 32'(b_stage), 32'd1);
      chk("t4_b_restart_terr",  32'(b_terr),  32'd0);
      chk("t4_b_restart_cc",    b_cc,         32'd0);
      chk("t4_a_ignores_start", 32'(a_stage), 32'd3);

      // Done coinciding with the watchdog limit wins (16th M3_WAIT cycle on b)
      uart_done = 1'b1; @(negedge Clock); uart_done = 1'b0;
      @(negedge Clock);
      repeat (15) @(negedge Clock);
      m3_done = 1'b1; @(negedge Clock); m3_done = 1'b0;
      chk("t5_b_tie_m2_start", 32'(b_m2_start), 32'd1);
      chk("t5_b_tie_stage",    32'(b_stage),    32'd3);
      chk("t5_b_tie_terr",     32'(b_terr),     32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
